// File: rtl/fret_write_scheduler.sv
// Single-writer scheduler for the fret display register: queues chart words,
// accumulates hit clear masks, and commits at most one update per frame at vblank start.
module fret_write_scheduler #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int V_ACTIVE   = 480
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [9:0]        screenY,
  input  logic              run,
  input  logic              chart_valid,
  input  logic [DATA_W-1:0] chart_data,
  output logic              chart_ready,
  input  logic              hit_valid,
  input  logic [DATA_W-1:0] hit_mask,
  output logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic [15:0]       frame_cnt
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [9:0]      VACTIVE_C = 10'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, COMMIT, WRITE} state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] pending_clear;
  logic              vblank_d;

  logic              vblank;
  logic              frame_start;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] base_word;
  logic [DATA_W-1:0] next_word;

  assign vblank      = (screenY >= VACTIVE_C);
  assign frame_start = vblank && !vblank_d;
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign chart_ready = !full;
  // Full blocks a push even when COMMIT pops in the same cycle.
  assign push        = chart_valid && !full;
  assign pop         = (state == COMMIT) && !empty;
  assign base_word   = empty ? data_out : fifo_mem[rd_ptr];
  assign next_word   = base_word & ~pending_clear;

  always_ff @(posedge clk) begin
    if (push && !Reset) fifo_mem[wr_ptr] <= chart_data;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= IDLE;
      write         <= 1'b0;
      data_out      <= '0;
      frame_cnt     <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      pending_clear <= '0;
      vblank_d      <= 1'b0;
    end else begin
      vblank_d <= vblank;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase

      // Hits arriving during COMMIT are not folded into this frame's word.
      if (state == COMMIT)
        pending_clear <= hit_valid ? hit_mask : '0;
      else if (hit_valid)
        pending_clear <= pending_clear | hit_mask;

      case (state)
        IDLE: begin
          write <= 1'b0;
          if (frame_start && run) state <= COMMIT;
        end
        COMMIT: begin
          data_out <= next_word;
          if (pop || (next_word != data_out)) begin
            write <= 1'b1;
            state <= WRITE;
          end else begin
            write <= 1'b0;
            state <= IDLE;
          end
        end
        WRITE: begin
          write <= 1'b0;
          state <= IDLE;
        end
        default: begin
          write <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fret_write_scheduler.sv
// Bench for fret_write_scheduler: directed frame scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_fret_write_scheduler;

  logic        clk;
  logic        Reset;
  logic [9:0]  screenY;
  logic        run;
  logic        chart_valid;
  logic [31:0] chart_data;
  logic        chart_ready;
  logic        hit_valid;
  logic [31:0] hit_mask;
  logic        write;
  logic [31:0] data_out;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_q [$];
  logic [31:0] m_pend  = '0;
  logic [31:0] m_data  = '0;
  logic [15:0] m_frame = '0;
  logic        m_vbd   = 1'b0;
  int          m_phase = 0;   // 0: waiting, 1: commit due this edge, 2: strobe showing
  logic        m_write = 1'b0;

  fret_write_scheduler #(.DATA_W(32), .FIFO_DEPTH(4), .V_ACTIVE(480)) dut (
    .clk(clk), .Reset(Reset), .screenY(screenY), .run(run),
    .chart_valid(chart_valid), .chart_data(chart_data), .chart_ready(chart_ready),
    .hit_valid(hit_valid), .hit_mask(hit_mask),
    .write(write), .data_out(data_out), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    logic vb, fs, full, popped;
    logic [31:0] base, nxt;
    @(posedge clk);
    if (Reset) begin
      m_q.delete();
      m_pend = '0; m_data = '0; m_frame = '0; m_vbd = 1'b0; m_phase = 0; m_write = 1'b0;
    end else begin
      vb = (screenY >= 10'd480);
      fs = vb && !m_vbd;
      m_vbd = vb;
      full = (m_q.size() >= 4);
      popped = 1'b0;
      base = m_data;
      if (m_phase == 1 && m_q.size() > 0) begin
        base = m_q.pop_front();
        popped = 1'b1;
      end
      if (chart_valid && !full) m_q.push_back(chart_data);
      if (fs) m_frame = m_frame + 16'd1;
      if (m_phase == 1) begin
        nxt = base & ~m_pend;
        m_pend = hit_valid ? hit_mask : '0;
        m_write = popped || (nxt != m_data);
        m_data = nxt;
        m_phase = m_write ? 2 : 0;
      end else begin
        if (hit_valid) m_pend = m_pend | hit_mask;
        m_write = 1'b0;
        if (m_phase == 2) m_phase = 0;
        else if (fs && run) m_phase = 1;
      end
    end
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    chart_valid = 1'b1;
    chart_data  = w;
    tick();
    chart_valid = 1'b0;
  endtask

  // One frame: enter vblank, dwell, leave; reports strobes and last written word.
  task automatic run_frame(output int nwr, output logic [31:0] last);
    nwr = 0;
    last = '0;
    screenY = 10'd479; tick();
    screenY = 10'd480;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (write) begin nwr++; last = data_out; end
    end
    screenY = 10'd0; tick();
    if (write) begin nwr++; last = data_out; end
  endtask

  task automatic test_reset();
    Reset = 1'b1; screenY = '0; run = 1'b0; chart_valid = 1'b0; chart_data = '0;
    hit_valid = 1'b0; hit_mask = '0;
    repeat (3) tick();
    Reset = 1'b0;
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", write); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame got=%0d exp=0", frame_cnt); end
    checks++; if (chart_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", chart_ready); end
  endtask

  task automatic test_single_commit();
    push_word(32'h0000_3215);
    run = 1'b1;
    screenY = 10'd479; tick();
    screenY = 10'd480; tick();
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL single_commit_cycle got=%b exp=0", write); end
    tick();
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL single_write got=%b exp=1", write); end
    checks++; if (data_out !== 32'h0000_3215) begin errors++; $display("FAIL single_data got=%h exp=00003215", data_out); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame got=%0d exp=1", frame_cnt); end
    tick();
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", write); end
    screenY = 10'd0; tick();
  endtask

  task automatic test_fifo_full();
    logic [31:0] words [5];
    int nwr;
    logic [31:0] last;
    for (int i = 0; i < 5; i++) words[i] = 32'h1000_0000 + 32'(i * 17 + 1);
    for (int i = 0; i < 5; i++) begin
      push_word(words[i]);
      if (i == 3) begin
        checks++; if (chart_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got=%b exp=0", chart_ready); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      run_frame(nwr, last);
      checks++; if (nwr != 1) begin errors++; $display("FAIL fifo_frame%0d_writes got=%0d exp=1", k, nwr); end
      checks++; if (last !== words[k]) begin errors++; $display("FAIL fifo_frame%0d_data got=%h exp=%h", k, last, words[k]); end
    end
    checks++; if (chart_ready !== 1'b1) begin errors++; $display("FAIL fifo_drained_ready got=%b exp=1", chart_ready); end
  endtask

  task automatic test_clear();
    int nwr;
    logic [31:0] last;
    push_word(32'h0000_00FF);
    run_frame(nwr, last);
    checks++; if (last !== 32'h0000_00FF) begin errors++; $display("FAIL clear_setup got=%h exp=000000ff", last); end
    hit_valid = 1'b1; hit_mask = 32'h0F; tick(); hit_valid = 1'b0;
    run_frame(nwr, last);
    checks++; if (nwr != 1) begin errors++; $display("FAIL clear_writes got=%0d exp=1", nwr); end
    checks++; if (last !== 32'h0000_00F0) begin errors++; $display("FAIL clear_data got=%h exp=000000f0", last); end
    run_frame(nwr, last);
    checks++; if (nwr != 0) begin errors++; $display("FAIL idle_frame_writes got=%0d exp=0", nwr); end
  endtask

  task automatic test_commit_hit();
    int nwr;
    logic [31:0] last;
    push_word(32'h3);
    screenY = 10'd479; tick();
    screenY = 10'd480; tick();
    hit_valid = 1'b1; hit_mask = 32'h1; tick(); hit_valid = 1'b0;
    checks++; if (write !== 1'b1 || data_out !== 32'h3) begin
      errors++; $display("FAIL commit_hit_now got=%b/%h exp=1/00000003", write, data_out); end
    screenY = 10'd0; tick();
    run_frame(nwr, last);
    checks++; if (nwr != 1 || last !== 32'h2) begin
      errors++; $display("FAIL commit_hit_carry got=%0d/%h exp=1/00000002", nwr, last); end
  endtask

  task automatic test_reset_in_write();
    int nwr;
    logic [31:0] last;
    push_word(32'hAB);
    screenY = 10'd479; tick();
    screenY = 10'd480; tick();
    tick();
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL rst_setup_write got=%b exp=1", write); end
    Reset = 1'b1; screenY = 10'd0; tick(); Reset = 1'b0;
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL rst_write got=%b exp=0", write); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", data_out); end
    run = 1'b0;
    push_word(32'h55);
    for (int k = 0; k < 3; k++) begin
      run_frame(nwr, last);
      checks++; if (nwr != 0) begin errors++; $display("FAIL run0_frame%0d_writes got=%0d exp=0", k, nwr); end
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL run0_frame_cnt got=%0d exp=3", frame_cnt); end
    run = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (write !== 1'b0) begin errors++; $display("FAIL run1_immediate got=%b exp=0", write); end
    end
    run_frame(nwr, last);
    checks++; if (nwr != 1 || last !== 32'h55) begin
      errors++; $display("FAIL run1_commit got=%0d/%h exp=1/00000055", nwr, last); end
  endtask

  task automatic test_random();
    int y;
    y = 0;
    for (int i = 0; i < 600; i++) begin
      Reset       = ($urandom_range(0, 199) == 0);
      run         = ($urandom_range(0, 9) != 0);
      chart_valid = ($urandom_range(0, 2) == 0);
      chart_data  = $urandom;
      hit_valid   = ($urandom_range(0, 3) == 0);
      hit_mask    = $urandom & $urandom;
      y = (y + 37) % 525;
      screenY = 10'(y);
      tick();
      checks++; if (write !== m_write) begin errors++; $display("FAIL rand_write cyc=%0d got=%b exp=%b", i, write, m_write); end
      checks++; if (data_out !== m_data) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, data_out, m_data); end
      checks++; if (frame_cnt !== m_frame) begin errors++; $display("FAIL rand_frame cyc=%0d got=%0d exp=%0d", i, frame_cnt, m_frame); end
      checks++; if (chart_ready !== (m_q.size() < 4)) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, chart_ready, m_q.size() < 4); end
    end
    Reset = 1'b0; chart_valid = 1'b0; hit_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_fifo_full();
    test_clear();
    test_commit_hit();
    test_reset_in_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
